// File: rtl/dlf_pkg.sv
// Shared definitions for the loop-filter gain scheduler: state encoding,
// per-state gain shifts and default thresholds.
package dlf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_ACQ    = 3'd2,
    ST_TRACK  = 3'd3,
    ST_LOCKED = 3'd4
  } dlf_state_e;

  localparam int LOCK_THR_DEF   = 8;
  localparam int LOCK_CNT_DEF   = 16;
  localparam int UNLOCK_CNT_DEF = 4;
  localparam int CLR_CYCLES_DEF = 4;

  typedef struct packed {
    logic [3:0] kp;
    logic [3:0] ki;
  } gain_t;

  // Wider bandwidth while acquiring, narrower as the loop settles.
  function automatic gain_t state_gain(dlf_state_e s);
    gain_t g;
    case (s)
      ST_CLEAR,
      ST_ACQ:    g = '{kp: 4'd1, ki: 4'd3};
      ST_TRACK:  g = '{kp: 4'd3, ki: 4'd6};
      ST_LOCKED: g = '{kp: 4'd4, ki: 4'd8};
      default:   g = '{kp: 4'd0, ki: 4'd0};
    endcase
    return g;
  endfunction

endpackage

// File: rtl/dlf_err_window.sv
// Phase-error window test: saturating 8-bit magnitude compared against LOCK_THR.
module dlf_err_window
  import dlf_pkg::*;
#(
  parameter int LOCK_THR = LOCK_THR_DEF
) (
  input  logic [7:0] phase_err,
  output logic       in_win
);

  logic [7:0] err_mag;

  // -128 has no positive 8-bit twin, so it clamps to 127.
  always_comb begin
    if (phase_err == 8'h80)  err_mag = 8'h7f;
    else if (phase_err[7])   err_mag = ~phase_err + 8'd1;
    else                     err_mag = phase_err;
    in_win = int'(err_mag) < LOCK_THR;
  end

endmodule

// File: rtl/dlf_gain_sched.sv
// Loop-filter gain scheduler: clears the integrator, then steps the PI gain
// shifts down through ACQ/TRACK/LOCKED as the phase error stays in window.
module dlf_gain_sched
  import dlf_pkg::*;
#(
  parameter int LOCK_THR   = LOCK_THR_DEF,
  parameter int LOCK_CNT   = LOCK_CNT_DEF,
  parameter int UNLOCK_CNT = UNLOCK_CNT_DEF,
  parameter int CLR_CYCLES = CLR_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       enable,
  input  logic [7:0] phase_err,
  input  logic       err_valid,
  output logic       dlf_clr,
  output logic [3:0] kp_shift,
  output logic [3:0] ki_shift,
  output logic       gain_upd,
  output logic       locked,
  output logic       lost_lock,
  output logic [2:0] state
);

  localparam int ACQ_CNT = (LOCK_CNT / 2 < 1) ? 1 : LOCK_CNT / 2;
  localparam int GW      = $clog2(LOCK_CNT + 1);
  localparam int BW      = $clog2(UNLOCK_CNT + 1);
  localparam int CW      = $clog2(CLR_CYCLES + 1);

  dlf_state_e    cur_st, nxt_st;
  logic [GW-1:0] good_cnt, nxt_good;
  logic [BW-1:0] bad_cnt, nxt_bad;
  logic [CW-1:0] clr_cnt, nxt_clr;
  logic          nxt_lost;
  logic          in_win;
  gain_t         nxt_gain;
  logic          nxt_upd;

  dlf_err_window #(.LOCK_THR(LOCK_THR)) u_win (
    .phase_err (phase_err),
    .in_win    (in_win)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur_st    <= ST_IDLE;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      clr_cnt   <= '0;
      dlf_clr   <= 1'b0;
      kp_shift  <= '0;
      ki_shift  <= '0;
      gain_upd  <= 1'b0;
      locked    <= 1'b0;
      lost_lock <= 1'b0;
    end else begin
      cur_st    <= nxt_st;
      good_cnt  <= nxt_good;
      bad_cnt   <= nxt_bad;
      clr_cnt   <= nxt_clr;
      dlf_clr   <= (nxt_st == ST_CLEAR);
      kp_shift  <= nxt_gain.kp;
      ki_shift  <= nxt_gain.ki;
      gain_upd  <= nxt_upd;
      locked    <= (nxt_st == ST_LOCKED);
      lost_lock <= nxt_lost;
    end
  end

  // Counters advance to their terminal value and transition there, so they
  // never exceed terminal-1 and cannot wrap.
  always_comb begin
    nxt_st   = cur_st;
    nxt_good = good_cnt;
    nxt_bad  = bad_cnt;
    nxt_clr  = clr_cnt;
    nxt_lost = 1'b0;
    if (!enable) begin
      nxt_st   = ST_IDLE;
      nxt_good = '0;
      nxt_bad  = '0;
      nxt_clr  = '0;
    end else begin
      case (cur_st)
        ST_IDLE: begin
          nxt_st  = ST_CLEAR;
          nxt_clr = '0;
        end
        ST_CLEAR: begin
          if (clr_cnt >= CW'(CLR_CYCLES - 1)) begin
            nxt_st  = ST_ACQ;
            nxt_clr = '0;
          end else begin
            nxt_clr = clr_cnt + CW'(1);
          end
        end
        ST_ACQ: if (err_valid) begin
          if (!in_win) nxt_good = '0;
          else if (good_cnt >= GW'(ACQ_CNT - 1)) begin
            nxt_st   = ST_TRACK;
            nxt_good = '0;
          end else nxt_good = good_cnt + GW'(1);
        end
        ST_TRACK: if (err_valid) begin
          if (!in_win) begin
            nxt_st   = ST_ACQ;
            nxt_good = '0;
          end else if (good_cnt >= GW'(LOCK_CNT - 1)) begin
            nxt_st   = ST_LOCKED;
            nxt_good = '0;
            nxt_bad  = '0;
          end else nxt_good = good_cnt + GW'(1);
        end
        ST_LOCKED: if (err_valid) begin
          if (in_win) nxt_bad = '0;
          else if (bad_cnt >= BW'(UNLOCK_CNT - 1)) begin
            nxt_st   = ST_ACQ;
            nxt_bad  = '0;
            nxt_good = '0;
            nxt_lost = 1'b1;
          end else nxt_bad = bad_cnt + BW'(1);
        end
        default: nxt_st = ST_IDLE;
      endcase
    end
  end

  // Registered outputs are derived from the state being entered.
  always_comb begin
    nxt_gain = state_gain(nxt_st);
    nxt_upd  = (nxt_gain != {kp_shift, ki_shift});
  end

  assign state = cur_st;

endmodule

// File: tb/tb_dlf_gain_sched.sv
// Randomized + directed bench for dlf_gain_sched against a per-sample
// behavioural model of the lock ladder.
module tb_dlf_gain_sched;

  localparam int LOCK_THR = 8, LOCK_CNT = 16, UNLOCK_CNT = 4, CLR_CYCLES = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] phase_err = 8'd0;
  logic       err_valid = 1'b0;
  logic       dlf_clr, gain_upd, locked, lost_lock;
  logic [3:0] kp_shift, ki_shift;
  logic [2:0] state;

  int total = 0;
  int bad = 0;

  dlf_gain_sched #(
    .LOCK_THR(LOCK_THR), .LOCK_CNT(LOCK_CNT),
    .UNLOCK_CNT(UNLOCK_CNT), .CLR_CYCLES(CLR_CYCLES)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .phase_err(phase_err),
    .err_valid(err_valid), .dlf_clr(dlf_clr), .kp_shift(kp_shift),
    .ki_shift(ki_shift), .gain_upd(gain_upd), .locked(locked),
    .lost_lock(lost_lock), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: 0 IDLE, 1 CLEAR, 2 ACQ, 3 TRACK, 4 LOCKED.
  int KP_T [5] = '{0, 1, 1, 3, 4};
  int KI_T [5] = '{0, 3, 3, 6, 8};
  int m_st = 0, m_good = 0, m_bad = 0, m_clr = 0;
  int m_kp = 0, m_ki = 0;
  bit m_upd = 0, m_ll = 0;

  always @(posedge clk or negedge rstn) begin
    int st, g, b, c, mag;
    bit inw, ll;
    if (!rstn) begin
      m_st <= 0; m_good <= 0; m_bad <= 0; m_clr <= 0;
      m_kp <= 0; m_ki <= 0; m_upd <= 0; m_ll <= 0;
    end else begin
      st = m_st; g = m_good; b = m_bad; c = m_clr; ll = 0;
      mag = $signed(phase_err);
      if (mag < 0) mag = -mag;
      if (mag > 127) mag = 127;
      inw = (mag < LOCK_THR);
      if (!enable) begin
        st = 0; g = 0; b = 0; c = 0;
      end else if (st == 0) begin
        st = 1; c = 0;
      end else if (st == 1) begin
        c = c + 1;                 // cycles spent clearing so far
        if (c == CLR_CYCLES) begin st = 2; c = 0; end
      end else if (err_valid) begin
        if (st == 2) begin
          g = inw ? g + 1 : 0;
          if (g >= LOCK_CNT / 2) begin st = 3; g = 0; end
        end else if (st == 3) begin
          if (!inw) begin st = 2; g = 0; end
          else begin
            g = g + 1;
            if (g >= LOCK_CNT) begin st = 4; g = 0; b = 0; end
          end
        end else begin
          b = inw ? 0 : b + 1;
          if (b >= UNLOCK_CNT) begin st = 2; b = 0; g = 0; ll = 1; end
        end
      end
      m_st <= st; m_good <= g; m_bad <= b; m_clr <= c; m_ll <= ll;
      m_kp <= KP_T[st]; m_ki <= KI_T[st];
      m_upd <= (KP_T[st] != m_kp) || (KI_T[st] != m_ki);
    end
  end

  always @(negedge clk) begin
    chk("state", int'(state), m_st);
    chk("kp", int'(kp_shift), m_kp);
    chk("ki", int'(ki_shift), m_ki);
    chk("dlf_clr", int'(dlf_clr), int'(m_st == 1));
    chk("locked", int'(locked), int'(m_st == 4));
    chk("gain_upd", int'(gain_upd), int'(m_upd));
    chk("lost_lock", int'(lost_lock), int'(m_ll));
  end

  // One call = one sampling edge; returns 1 time unit after that edge.
  task automatic sample(input bit en, input bit v, input int e);
    @(negedge clk);
    enable = en; err_valid = v; phase_err = 8'(e);
    @(posedge clk);
    #1;
  endtask

  task automatic samples(input int n, input int e);
    for (int i = 0; i < n; i++) sample(1, 1, e);
  endtask

  initial begin
    int r, e;
    bit en, v;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_kp", int'(kp_shift), 0);
    chk("rst_upd", int'(gain_upd), 0);
    @(negedge clk);
    rstn = 1'b1;

    // Enable: four clear cycles, then ACQ with unchanged gains.
    sample(1, 0, 0);
    chk("clr_entry_state", int'(state), 1);
    chk("clr_entry_upd", int'(gain_upd), 1);
    chk("clr_entry_kp", int'(kp_shift), 1);
    chk("clr_entry_ki", int'(ki_shift), 3);
    for (int i = 0; i < 3; i++) begin
      sample(1, 0, 0);
      chk("clr_hold", int'(dlf_clr), 1);
    end
    sample(1, 0, 0);
    chk("acq_state", int'(state), 2);
    chk("acq_clr", int'(dlf_clr), 0);
    chk("acq_no_upd", int'(gain_upd), 0);

    // Broken run of in-window samples keeps ACQ; eighth consecutive -> TRACK.
    samples(7, -5);
    sample(1, 1, 8);
    samples(7, -5);
    sample(1, 0, 0);
    chk("acq_hold", int'(state), 2);
    sample(1, 1, -5);
    chk("track_state", int'(state), 3);
    chk("track_kp", int'(kp_shift), 3);
    chk("track_ki", int'(ki_shift), 6);
    chk("track_upd", int'(gain_upd), 1);
    samples(15, 3);
    chk("track_hold", int'(state), 3);
    sample(1, 1, 3);
    chk("lock_state", int'(state), 4);
    chk("lock_flag", int'(locked), 1);
    chk("lock_kp", int'(kp_shift), 4);
    chk("lock_ki", int'(ki_shift), 8);
    chk("model_pin_lock", m_st, 4);

    // Unlock: an in-window sample resets the bad run.
    samples(3, -128);
    sample(1, 1, 0);
    samples(3, -128);
    chk("still_locked", int'(locked), 1);
    sample(1, 1, -128);
    chk("lost_pulse", int'(lost_lock), 1);
    chk("lost_locked", int'(locked), 0);
    chk("lost_state", int'(state), 2);
    chk("lost_kp", int'(kp_shift), 1);
    sample(1, 0, 0);
    chk("lost_one_cycle", int'(lost_lock), 0);

    // Relock then disable.
    samples(24, 0);
    chk("relock", int'(state), 4);
    sample(0, 0, 0);
    chk("dis_state", int'(state), 0);
    chk("dis_kp", int'(kp_shift), 0);
    chk("dis_upd", int'(gain_upd), 1);
    chk("dis_no_lost", int'(lost_lock), 0);

    // Async reset while in TRACK.
    sample(1, 0, 0);
    repeat (4) sample(1, 0, 0);
    samples(8, 1);
    chk("pre_rst_track", int'(state), 3);
    #2 rstn = 1'b0;
    #1;
    chk("arst_state", int'(state), 0);
    chk("arst_kp", int'(kp_shift), 0);
    chk("arst_ki", int'(ki_shift), 0);
    chk("arst_upd", int'(gain_upd), 0);
    @(negedge clk);
    rstn = 1'b1; enable = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_idle", int'(state), 0);

    // Random traffic, mostly small errors so the ladder is exercised.
    for (int i = 0; i < 4000; i++) begin
      en = ($urandom_range(255) != 0);
      v  = ($urandom_range(3) != 0);
      r  = $urandom_range(99);
      if (r < 93)      e = $urandom_range(16) - 8;
      else if (r < 97) e = int'($urandom_range(255)) - 128;
      else             e = -128;
      sample(en, v, e);
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dlf_gain_sched.md
DLF_GAIN_SCHED -- requirements
Module: dlf_gain_sched

Interface
REQ-001 Parameter LOCK_THR, default 8: phase-error magnitude window; a sample is in-window when |err| < LOCK_THR.
REQ-002 Parameter LOCK_CNT, default 16: consecutive in-window samples that promote TRACK to LOCKED; ACQ to TRACK uses LOCK_CNT/2.
REQ-003 Parameter UNLOCK_CNT, default 4: consecutive out-of-window samples that drop LOCKED to ACQ.
REQ-004 Parameter CLR_CYCLES, default 4: length of the filter-clear pulse.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rstn  input  1  reset, asynchronous, active-low.
REQ-007 enable  input  1  level; 1 = run the scheduler, 0 = return to IDLE.
REQ-008 phase_err  input  8  signed two's-complement phase error from the detector.
REQ-009 err_valid  input  1  single-cycle qualifier for phase_err.
REQ-010 dlf_clr  output  1  clears the loop-filter integrator while high.
REQ-011 kp_shift  output  4  proportional-gain right-shift applied to the loop filter.
REQ-012 ki_shift  output  4  integral-gain right-shift applied to the loop filter.
REQ-013 gain_upd  output  1  one-cycle pulse on every kp_shift/ki_shift change.
REQ-014 locked  output  1  high only in LOCKED.
REQ-015 lost_lock  output  1  one-cycle pulse on the LOCKED->ACQ transition.
REQ-016 state  output  3  current state encoding: IDLE=0, CLEAR=1, ACQ=2, TRACK=3, LOCKED=4.

Function
REQ-017 All outputs SHALL be registered; state, gains and flags SHALL update on the same edge that samples the qualifying input.
REQ-018 |err| SHALL be computed on 8 bits, with -128 saturating to 127.
REQ-019 IDLE: gains kp=0, ki=0, dlf_clr=0; enable=1 -> CLEAR.
REQ-020 CLEAR: dlf_clr=1 for exactly CLR_CYCLES cycles, gains kp=1, ki=3, then -> ACQ.
REQ-021 ACQ: gains kp=1, ki=3; in-window err_valid increments good_cnt; out-of-window err_valid zeroes good_cnt; good_cnt reaching LOCK_CNT/2 -> TRACK with good_cnt=0.
REQ-022 TRACK: gains kp=3, ki=6; good_cnt reaching LOCK_CNT -> LOCKED; any out-of-window err_valid -> ACQ with good_cnt=0.
REQ-023 LOCKED: gains kp=4, ki=8; out-of-window err_valid increments bad_cnt; in-window err_valid zeroes bad_cnt; bad_cnt reaching UNLOCK_CNT -> ACQ, lost_lock=1 for one cycle, bad_cnt=0.
REQ-024 err_valid SHALL be ignored in IDLE and CLEAR; cycles without err_valid SHALL leave counters unchanged.
REQ-025 Counters SHALL saturate at their terminal value and never wrap.
REQ-026 enable=0 in any state SHALL force IDLE on the next edge, with counters zeroed, dlf_clr=0 and locked=0; the gain change to 0 SHALL raise gain_upd.
REQ-027 gain_upd SHALL NOT pulse when a transition keeps the same gains (CLEAR->ACQ).

Reset
REQ-028 rstn low SHALL asynchronously force state=IDLE, all counters=0, and all outputs=0, including kp_shift and ki_shift.
REQ-029 Reset deassertion SHALL take effect on the next rising edge; reset mid-operation SHALL abort CLEAR or lock with no lost_lock pulse.

Structure
REQ-030 The state encoding, the per-state gain constants and the default thresholds SHALL reside in a shared package, dlf_pkg.
REQ-031 The window comparison (abs-saturate plus compare) SHALL be one sub-module, dlf_err_window.

Verification
REQ-032 Reset, then enable=1 -> dlf_clr high for 4 cycles, state 1 then 2, kp=1, ki=3, with one gain_upd pulse on entry to CLEAR.
REQ-033 8 in-window samples (err=3) -> TRACK, kp=3, ki=6, gain_upd pulse; 16 more samples -> LOCKED, locked=1, kp=4, ki=8.
REQ-034 In ACQ, 7 samples with err=-5 then one with err=8 then 7 with err=-5 -> remains in ACQ; the 8th consecutive in-window sample -> TRACK.
REQ-035 LOCKED, then 3 samples with err=-128, then err=0, then 4 samples with err=-128 -> lost_lock pulse on the 4th sample, locked=0, state=ACQ, kp=1.
REQ-036 In LOCKED, enable=0 -> IDLE next cycle, gains 0, gain_upd pulse, no lost_lock.
REQ-037 In TRACK, assert rstn low asynchronously mid-cycle -> all outputs 0 immediately; release -> IDLE.
